// File: rtl/lfsr_share_ctrl_pkg.sv
// Shared constants and types for the shared-LFSR random byte controller.
package lfsr_pkg;

  localparam int         LFSR_W   = 8;
  // Feedback taps at bits 4, 3, 2 and 0.
  localparam logic [7:0] TAP_MASK = 8'h1D;
  // Substituted for a zero seed, which would otherwise lock the LFSR at zero.
  localparam logic [7:0] ZERO_SUB = 8'h01;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_WARMUP = 1'b1
  } fsm_e;

endpackage

// File: rtl/lfsr_share_ctrl_if.sv
// Request/grant bus between the random-byte consumers and the controller.
// Handshake: a requester raises req[i] and holds it until it sees gnt[i];
// gnt is a one-cycle registered pulse and rnd_data is valid in that same
// cycle. Dropping req[i] before its grant withdraws the request. A load
// strobe takes priority over all requests in the cycle it is sampled.
interface lfsr_share_ctrl_if #(
  parameter int NREQ = 2
) ();
  import lfsr_pkg::*;

  logic            load;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rnd_data;
  logic            busy;
  fsm_e            dbg_state;

  modport master (
    output load, seed, req,
    input  gnt, rnd_data, busy, dbg_state
  );

  modport slave (
    input  load, seed, req,
    output gnt, rnd_data, busy, dbg_state
  );
endinterface

// File: rtl/lfsr_share_ctrl_lfsr8_step.sv
// One step of the 8-bit Fibonacci LFSR: shift left, feedback into bit 0.
module lfsr8_step
  import lfsr_pkg::*;
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  // Feedback is the XOR of the tapped bits.
  always_comb begin
    nxt = {cur[6:0], ^(cur & TAP_MASK)};
  end

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Shares one LFSR between NREQ requesters with round-robin arbitration,
// with seed load and a post-load warm-up of free-running steps.
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int         NREQ       = 2,
  parameter int         WARMUP     = 8,
  parameter logic [7:0] RESET_SEED = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_share_ctrl_if.slave   bus
);

  localparam int         PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] WARM_INIT  = 8'(WARMUP);
  localparam fsm_e       LOAD_STATE = (WARMUP > 0) ? ST_WARMUP : ST_IDLE;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  fsm_e            state;
  fsm_e            state_nxt;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_stepped;
  logic [7:0]      warm_cnt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   scan_idx;
  logic            win_found;
  logic            grant_en;
  logic            busy_c;
  logic [NREQ-1:0] gnt_q;
  logic [7:0]      rnd_q;

  lfsr8_step u_step (
    .cur (lfsr),
    .nxt (lfsr_stepped)
  );

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    rr_nxt = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: load restarts warm-up from anywhere; warm-up ends on its last step.
  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = LOAD_STATE;
    end else if (state == ST_WARMUP && warm_cnt <= 8'd1) begin
      state_nxt = ST_IDLE;
    end
  end

  // FSM outputs: grants only from IDLE, and never in a load cycle.
  always_comb begin
    busy_c   = (state == ST_WARMUP);
    grant_en = (state == ST_IDLE) && !bus.load && win_found;
  end

  // Datapath: LFSR, warm-up count, round-robin pointer and registered grant/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr     <= RESET_SEED;
      warm_cnt <= 8'd0;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      rnd_q    <= 8'h00;
    end else begin
      gnt_q <= '0;
      if (bus.load) begin
        lfsr     <= (bus.seed == 8'h00) ? ZERO_SUB : bus.seed;
        warm_cnt <= WARM_INIT;
      end else if (state == ST_WARMUP) begin
        lfsr     <= lfsr_stepped;
        warm_cnt <= warm_cnt - 8'd1;
      end else if (grant_en) begin
        gnt_q  <= ONE_HOT0 << win_idx;
        rnd_q  <= lfsr;
        lfsr   <= lfsr_stepped;
        rr_ptr <= rr_nxt;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rnd_data  = rnd_q;
  assign bus.busy      = busy_c;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Bench for lfsr_share_ctrl: two instances (no warm-up and 8-step warm-up)
// share one stimulus stream and are checked against a behavioural model.
module tb_lfsr_share_ctrl;
  import lfsr_pkg::*;

  localparam int NREQ = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            load;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;

  lfsr_share_ctrl_if #(.NREQ(NREQ)) bus0 ();
  lfsr_share_ctrl_if #(.NREQ(NREQ)) bus1 ();

  assign bus0.load = load;
  assign bus0.seed = seed;
  assign bus0.req  = req;
  assign bus1.load = load;
  assign bus1.seed = seed;
  assign bus1.req  = req;

  lfsr_share_ctrl #(.NREQ(NREQ), .WARMUP(0), .RESET_SEED(8'h01)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  lfsr_share_ctrl #(.NREQ(NREQ), .WARMUP(8), .RESET_SEED(8'h01)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // ---------------- reference model ----------------
  int m_lfsr [2];
  int m_warm [2];   // warm-up steps still to run; 0 means idle
  int m_ptr  [2];
  int m_rnd  [2];
  int m_gnt  [2];
  int warm_of [2] = '{0, 8};
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  int checks   = 0;
  int failures = 0;

  // Next LFSR value from the rule: shift left, new bit 0 = parity of bits 4,3,2,0.
  function automatic int ref_step(input int v);
    int fb;
    fb = ((v >> 4) % 2) + ((v >> 3) % 2) + ((v >> 2) % 2) + (v % 2);
    return ((v * 2) % 256) + (fb % 2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lfsr[k] = 1;
      m_warm[k] = 0;
      m_ptr[k]  = 0;
      m_rnd[k]  = 0;
      m_gnt[k]  = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int rq;
    int w;
    rq = int'(req);
    for (int k = 0; k < 2; k++) begin
      m_gnt[k] = 0;
      if (load) begin
        m_lfsr[k] = (seed == 8'h00) ? 1 : int'(seed);
        m_warm[k] = warm_of[k];
      end else if (m_warm[k] > 0) begin
        m_lfsr[k] = ref_step(m_lfsr[k]);
        m_warm[k] = m_warm[k] - 1;
      end else if (rq != 0) begin
        w = -1;
        for (int off = 0; off < NREQ; off++) begin
          if (w < 0 && ((rq >> ((m_ptr[k] + off) % NREQ)) % 2) == 1)
            w = (m_ptr[k] + off) % NREQ;
        end
        m_gnt[k] = 1 << w;
        m_rnd[k] = m_lfsr[k];
        if (k == 0) exp_q0.push_back(8'(m_lfsr[k]));
        else        exp_q1.push_back(8'(m_lfsr[k]));
        m_lfsr[k] = ref_step(m_lfsr[k]);
        m_ptr[k]  = (w + 1) % NREQ;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_inst(input int k, input logic [NREQ-1:0] g, input logic [7:0] r,
                              input logic b, input fsm_e st);
    logic [7:0] e;
    check($sformatf("gnt%0d", k), 32'(g), 32'(m_gnt[k]));
    check($sformatf("rnd%0d", k), 32'(r), 32'(m_rnd[k]));
    check($sformatf("busy%0d", k), 32'(b), (m_warm[k] > 0) ? 32'd1 : 32'd0);
    check($sformatf("state%0d", k), 32'(st), (m_warm[k] > 0) ? 32'(ST_WARMUP) : 32'(ST_IDLE));
    if (g != '0) begin
      e = 8'h00;
      if (k == 0) begin
        check("sb_avail0", 32'(exp_q0.size() > 0), 32'd1);
        if (exp_q0.size() > 0) e = exp_q0.pop_front();
      end else begin
        check("sb_avail1", 32'(exp_q1.size() > 0), 32'd1);
        if (exp_q1.size() > 0) e = exp_q1.pop_front();
      end
      check($sformatf("sb_data%0d", k), 32'(r), 32'(e));
    end
  endtask

  task automatic compare_all();
    compare_inst(0, bus0.gnt, bus0.rnd_data, bus0.busy, bus0.dbg_state);
    compare_inst(1, bus1.gnt, bus1.rnd_data, bus1.busy, bus1.dbg_state);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [7:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
  endtask

  // Runs the remaining warm-up of dut1 and checks busy lasted 8 cycles incl. the load cycle.
  task automatic warm_count_check(input string tag);
    int busy_cycles;
    busy_cycles = int'(bus1.busy);
    for (int i = 0; i < 8; i++) begin
      tick();
      busy_cycles += int'(bus1.busy);
    end
    check(tag, 32'(busy_cycles), 32'd8);
  endtask

  logic [7:0] seq01 [5] = '{8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C};

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] s1;
    logic [7:0] s2;
    int exp8;

    load = 1'b0;
    seed = 8'h00;
    req  = '0;
    model_reset();

    // Reset values.
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Seed 01, single requester, back-to-back grants.
    do_load(8'h01);
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seq01_gnt", 32'(bus0.gnt), 32'h1);
      check("seq01_rnd", 32'(bus0.rnd_data), 32'(seq01[i]));
    end

    // Zero seed is substituted by 01.
    req = '0;
    tick();
    do_load(8'h00);
    req = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seq00_rnd", 32'(bus0.rnd_data), 32'(seq01[i]));
    end

    // Warm-up of 8 on dut1, both requesters alternate afterwards.
    req = '0;
    do_load(8'h01);
    req = 2'b11;
    warm_count_check("warm_busy_len");
    tick();
    check("warm_first_rnd", 32'(bus1.rnd_data), 32'h0000_00CD);
    for (int i = 0; i < 4; i++) tick();

    // Load in the same cycle as requests: no grant, then grant of the seed.
    s1 = 8'($urandom_range(1, 255));
    load = 1'b1;
    seed = s1;
    req  = 2'b11;
    tick();
    check("load_req_nogrant", 32'(bus0.gnt), 32'h0);
    load = 1'b0;
    tick();
    check("load_req_seed", 32'(bus0.rnd_data), 32'(s1));
    req = '0;
    for (int i = 0; i < 9; i++) tick();

    // Asynchronous reset in the middle of warm-up.
    do_load(8'($urandom_range(0, 255)));
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_busy_async", 32'(bus1.busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req = 2'b01;
    tick();
    check("rst_first0", 32'(bus0.rnd_data), 32'h01);
    check("rst_first1", 32'(bus1.rnd_data), 32'h01);

    // Reload during warm-up at count 5 restarts seed and count.
    req = '0;
    s1 = 8'($urandom_range(1, 255));
    s2 = 8'($urandom_range(1, 255));
    do_load(s1);
    for (int i = 0; i < 3; i++) tick();
    do_load(s2);
    req = 2'b10;
    warm_count_check("reload_busy_len");
    tick();
    exp8 = int'(s2);
    for (int i = 0; i < 8; i++) exp8 = ref_step(exp8);
    check("reload_first_rnd", 32'(bus1.rnd_data), 32'(exp8));

    // Randomized traffic with occasional loads (including zero seeds).
    for (int n = 0; n < 300; n++) begin
      req  = NREQ'($urandom_range(0, 3));
      load = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    load = 1'b0;
    req  = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
Owns one 8-bit Fibonacci LFSR and shares its output between NREQ requesters using round-robin arbitration. It loads a seed on command and runs a configurable warm-up of free-running steps after each load. Each grant delivers the current LFSR byte to the winner and advances the LFSR by one step. It sits between the random-number consumers (test-pattern and jitter logic) and the shift-register datapath.

Parameters:
NREQ, 2, number of requesters (2..8)
WARMUP, 8, LFSR steps run after every seed load before grants resume (0..255)
RESET_SEED, 8'h01, LFSR value after reset; must be nonzero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  seed load strobe, sampled on clk
seed  input  8  seed value, valid with load
req  input  NREQ  request per requester; held high until that requester's gnt
gnt  output  NREQ  registered one-hot grant, one-cycle pulse
rnd_data  output  8  byte for the current grant; valid while any gnt bit is high, held otherwise
busy  output  1  high during WARMUP state

Behaviour:
- Step function: next[7:1] = cur[6:0]; next[0] = cur[4]^cur[3]^cur[2]^cur[0].
- Reset (rst=0, asynchronous):
  - lfsr=RESET_SEED, fsm=IDLE, gnt=0, rnd_data=8'h00, busy=0, rr_ptr=0, warm_cnt=0.
  - Reset during WARMUP or mid-grant aborts immediately to these values.
- FSM states are IDLE and WARMUP. busy = (fsm==WARMUP), registered.
- load=1 in any state:
  - lfsr <= (seed==0) ? 8'h01 : seed. A zero seed would lock the LFSR.
  - warm_cnt <= WARMUP.
  - fsm <= WARMUP if WARMUP>0, else IDLE.
  - No grant is issued that cycle; load has priority over req.
  - A load during WARMUP restarts the seed and the count.
- WARMUP:
  - Each cycle: lfsr steps and warm_cnt decrements.
  - When warm_cnt==1 the next state is IDLE.
  - gnt stays 0.
- IDLE with |req and no load, at the clock edge:
  - winner = first set req bit searching from rr_ptr upward, wrapping at NREQ-1 to 0.
  - gnt <= onehot(winner), rnd_data <= lfsr (pre-step value).
  - lfsr <= step(lfsr), rr_ptr <= (winner+1) mod NREQ.
- Latency and throughput:
  - Latency is 1 cycle from req high to gnt.
  - Throughput is one grant per cycle.
  - Both requesters held high alternate grants every cycle.
  - A single requester held high receives back-to-back grants.
- No request: gnt <= 0; lfsr and rnd_data hold; rr_ptr holds.
- A requester deasserting req before its grant is legal; it is simply skipped.
- Output invariants:
  - gnt is never multi-hot.
  - gnt is 0 in any cycle following a load edge.

Decomposition:
- Shared package (lfsr_pkg):
  - LFSR width constant (8) and tap mask (8'h1D, bits 4,3,2,0).
  - Zero-seed substitute (8'h01).
  - FSM state enum {IDLE, WARMUP}.
- Sub-module lfsr8_step: combinational next-state function, shared with the existing shifter datapath.
- Round-robin arbiter logic stays inline.

Test Plan:
- Reset then load seed=8'h01, WARMUP=0, req=2'b01 held for 5 cycles -> gnt[0] pulses each cycle, rnd_data = 01,03,07,0E,1C.
- load seed=8'h00, WARMUP=0 -> identical to the above sequence (zero substituted by 01).
- load seed=8'h01, WARMUP=8, req=2'b11 -> busy high exactly 8 cycles, no gnt during them; then gnt alternates 01,10,01,10 and rnd_data = CD, next step, ... with rr fairness.
- load asserted in the same cycle as req during IDLE -> no gnt that cycle, lfsr=seed; grant follows on the next cycle.
- Reset asserted (rst=0) mid-WARMUP after 3 steps -> busy=0 and gnt=0 immediately (asynchronously); after release the first grant returns RESET_SEED=8'h01.
- Second load during WARMUP at count 5 -> busy extends to a full 8 more cycles from the new load; first grant data = 8-step value of the new seed.
